// File: rtl/alu_pkg.sv
// Shared types and helpers for the two-requester ALU operation scheduler.
package alu_pkg;

    localparam int ALU_OP_COUNT = 6;

    typedef enum logic [2:0] {
        OP_SEL0 = 3'd0,
        OP_SEL1 = 3'd1,
        OP_SEL2 = 3'd2,
        OP_SEL3 = 3'd3,
        OP_SEL4 = 3'd4,
        OP_SEL5 = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op < 3'(ALU_OP_COUNT);
    endfunction

    // Illegal codes are steered to select 0 so the ALU mux default is never chosen.
    function automatic alu_op_t sel_for(input logic [2:0] op);
        return op_is_legal(op) ? alu_op_t'(op) : OP_SEL0;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational, the last-grant state lives in the caller.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic    i_a_valid,
    input  logic    i_b_valid,
    input  req_id_t i_last_grant,
    output logic    o_grant,
    output req_id_t o_grant_id
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        o_grant    = i_a_valid | i_b_valid;
        o_grant_id = REQ_A;
        if (i_a_valid && i_b_valid) begin
            o_grant_id = (i_last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (i_b_valid) begin
            o_grant_id = REQ_B;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one external ALU between requesters A and B: arbitrate, execute for one cycle,
// then hold the tagged result on a valid/ready response channel.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [2:0]   a_op,
    input  logic [N-1:0] a_x,
    input  logic [N-1:0] a_y,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [2:0]   b_op,
    input  logic [N-1:0] b_x,
    input  logic [N-1:0] b_y,
    output logic [N-1:0] alu_x,
    output logic [N-1:0] alu_y,
    output logic [2:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data,
    output logic         resp_err
);

    sched_state_t r_state;
    sched_state_t w_next_state;
    req_id_t      r_last_grant;
    req_id_t      r_req_id;
    req_id_t      r_resp_id;
    logic         r_illegal;
    alu_op_t      r_alu_sel;
    logic [N-1:0] r_alu_x;
    logic [N-1:0] r_alu_y;
    logic [N-1:0] r_resp_data;
    logic         r_resp_err;

    logic         w_grant;
    req_id_t      w_grant_id;
    logic         w_accept;
    logic [2:0]   w_op;
    logic [N-1:0] w_x;
    logic [N-1:0] w_y;

    rr_arbiter2 u_arb (
        .i_a_valid    (a_valid),
        .i_b_valid    (b_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_id   (w_grant_id)
    );

    assign w_op = (w_grant_id == REQ_B) ? b_op : a_op;
    assign w_x  = (w_grant_id == REQ_B) ? b_x  : a_x;
    assign w_y  = (w_grant_id == REQ_B) ? b_y  : a_y;

    // Readies are masked while rst is high so they read 0 even when a requester is valid.
    assign w_accept = (r_state == IDLE) && w_grant && !rst;

    always_comb begin
        w_next_state = r_state;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                a_ready = w_accept && (w_grant_id == REQ_A);
                b_ready = w_accept && (w_grant_id == REQ_B);
                if (w_grant) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand/select registers double as the ALU drive, so they hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_B;
            r_req_id     <= REQ_A;
            r_illegal    <= 1'b0;
            r_alu_sel    <= OP_SEL0;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_resp_id    <= REQ_A;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_id;
                r_req_id     <= w_grant_id;
                r_illegal    <= !op_is_legal(w_op);
                r_alu_sel    <= sel_for(w_op);
                r_alu_x      <= w_x;
                r_alu_y      <= w_y;
            end
            if (r_state == EXEC) begin
                r_resp_id   <= r_req_id;
                r_resp_data <= r_illegal ? '0 : alu_result;
                r_resp_err  <= r_illegal;
            end
        end
    end

    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_sel   = r_alu_sel;
    assign resp_id   = r_resp_id;
    assign resp_data = r_resp_data;
    assign resp_err  = r_resp_err;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Randomised and directed bench for alu_op_scheduler: a cycle-level reference model predicts
// grants and responses into a queue; an independent monitor pops and compares responses.
module tb_alu_op_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [2:0]   a_op, b_op;
    logic [N-1:0] a_x, a_y, b_x, b_y;
    logic [N-1:0] alu_x, alu_y, alu_result;
    logic [2:0]   alu_sel;
    logic         resp_valid, resp_ready, resp_id, resp_err;
    logic [N-1:0] resp_data;

    alu_op_scheduler #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_op       (a_op),
        .a_x        (a_x),
        .a_y        (a_y),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_op       (b_op),
        .b_x        (b_x),
        .b_y        (b_y),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU; selects 6 and 7 give an all-ones "undriven" value.
    function automatic logic [N-1:0] alu_fn(input logic [2:0] sel, input logic [N-1:0] x,
                                            input logic [N-1:0] y);
        case (sel)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return ~x;
            default: return {N{1'b1}};
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_sel, alu_x, alu_y);

    typedef struct {
        logic         id;
        logic [N-1:0] data;
        logic         err;
    } resp_t;

    resp_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           m_acc_cyc = -10;
    int           m_hs_cyc  = -10;
    logic         m_pend = 1'b0;
    logic         m_last = 1'b1;
    logic         me_a, me_b, m_legal;
    logic [2:0]   m_op, psel, lsel;
    logic [N-1:0] m_x, m_y, px, py, lx, ly;
    resp_t        m_r;
    int           fire_log[$];
    int           acc_log[$];
    logic         a_fire, b_fire;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one operation in flight; result due two cycles after accept;
    // free again the cycle after the response handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_last = 1'b1;
            lx = '0;
            ly = '0;
            lsel = '0;
        end else begin
            if (m_pend && m_hs_cyc > m_acc_cyc && m_hs_cyc < cyc) m_pend = 1'b0;
            me_a = 1'b0;
            me_b = 1'b0;
            if (!m_pend) begin
                if (a_valid && b_valid) begin
                    me_a = m_last;
                    me_b = !m_last;
                end else begin
                    me_a = a_valid;
                    me_b = b_valid;
                end
            end
            check("a_ready", 32'(a_ready), 32'(me_a));
            check("b_ready", 32'(b_ready), 32'(me_b));
            check("resp_valid", 32'(resp_valid), 32'(m_pend && (cyc >= m_acc_cyc + 2)));
            if (m_pend && cyc == m_acc_cyc + 1) begin
                check("exec_alu_sel", 32'(alu_sel), 32'(psel));
                check("exec_alu_x", 32'(alu_x), 32'(px));
                check("exec_alu_y", 32'(alu_y), 32'(py));
                lsel = psel;
                lx = px;
                ly = py;
            end else begin
                check("hold_alu_sel", 32'(alu_sel), 32'(lsel));
                check("hold_alu_x", 32'(alu_x), 32'(lx));
                check("hold_alu_y", 32'(alu_y), 32'(ly));
            end
            if (me_a || me_b) begin
                m_op = me_b ? b_op : a_op;
                m_x  = me_b ? b_x : a_x;
                m_y  = me_b ? b_y : a_y;
                m_legal = (m_op <= 3'd5);
                m_r.id   = me_b;
                m_r.err  = !m_legal;
                m_r.data = m_legal ? alu_fn(m_op, m_x, m_y) : '0;
                exp_q.push_back(m_r);
                m_pend    = 1'b1;
                m_acc_cyc = cyc;
                m_last    = me_b;
                psel = m_legal ? m_op : 3'd0;
                px   = m_x;
                py   = m_y;
            end
        end
    end

    // Response monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                check("resp_id", 32'(resp_id), 32'(exp_q[0].id));
                check("resp_data", 32'(resp_data), 32'(exp_q[0].data));
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    m_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        if (a_fire) begin
            fire_log.push_back(0);
            acc_log.push_back(cyc);
        end
        if (b_fire) begin
            fire_log.push_back(1);
            acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (a_fire) a_valid = 1'b0;
        if (b_fire) b_valid = 1'b0;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        a_valid = 1'b1;
        a_op = op;
        a_x = x;
        a_y = y;
    endtask

    task automatic drive_b(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        b_valid = 1'b1;
        b_op = op;
        b_x = x;
        b_y = y;
    endtask

    task automatic wait_fired();
        int k = 0;
        while ((a_valid || b_valid) && k < 50) begin
            tick();
            k++;
        end
        check("accept_timeout", 32'(k < 50), 32'd1);
    endtask

    task automatic wait_quiet();
        int k = 0;
        while ((a_valid || b_valid || resp_valid || exp_q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(k < 200), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_ready"}, 32'(a_ready), 32'd0);
        check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_alu_x"}, 32'(alu_x), 32'd0);
        check({tag, "_alu_y"}, 32'(alu_y), 32'd0);
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_op = 3'd0; a_x = '0; a_y = '0;
        b_valid = 1'b1; b_op = 3'd0; b_x = '0; b_y = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("por");
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single A operation: accept, execute, respond on consecutive cycles.
        drive_a(3'd2, 4'hA, 4'h3);
        tick();
        check("t1_accepted_a", 32'(fire_log.size() == 1 && fire_log[0] == 0), 32'd1);
        check("t1_exec_sel", 32'(alu_sel), 32'd2);
        check("t1_exec_x", 32'(alu_x), 32'hA);
        tick();
        check("t1_resp_valid", 32'(resp_valid), 32'd1);
        check("t1_resp_id", 32'(resp_id), 32'd0);
        check("t1_resp_data", 32'(resp_data), 32'h2);
        wait_quiet();

        // Two ties in a row after reset: A, B, A, B.
        do_reset();
        fire_log.delete();
        drive_a(3'd0, 4'h1, 4'h2);
        drive_b(3'd3, 4'h4, 4'h8);
        wait_fired();
        drive_a(3'd4, 4'hF, 4'h5);
        drive_b(3'd5, 4'h6, 4'h0);
        wait_fired();
        check("t2_grant_count", 32'(fire_log.size()), 32'd4);
        check("t2_grant_order", 32'(fire_log.size() == 4 && fire_log[0] == 0 && fire_log[1] == 1
                                   && fire_log[2] == 0 && fire_log[3] == 1), 32'd1);
        wait_quiet();

        // Illegal opcode from B.
        drive_b(3'd7, 4'h5, 4'h6);
        tick();
        check("t3_exec_sel", 32'(alu_sel), 32'd0);
        tick();
        check("t3_resp_err", 32'(resp_err), 32'd1);
        check("t3_resp_data", 32'(resp_data), 32'd0);
        check("t3_resp_id", 32'(resp_id), 32'd1);
        wait_quiet();

        // Back-pressure in HOLD for five cycles, with both requesters waiting.
        resp_ready = 1'b0;
        drive_a(3'd1, 4'h9, 4'h4);
        tick();
        tick();
        drive_a(3'd3, 4'h1, 4'h2);
        drive_b(3'd4, 4'h5, 4'h6);
        fire_log.delete();
        repeat (5) begin
            tick();
            check("t4_resp_valid", 32'(resp_valid), 32'd1);
            check("t4_resp_data", 32'(resp_data), 32'h5);
        end
        check("t4_no_accept", 32'(fire_log.size()), 32'd0);
        resp_ready = 1'b1;
        tick();
        tick();
        check("t4_resume_b", 32'(fire_log.size() == 1 && fire_log[0] == 1), 32'd1);
        check("t4_resume_gap", 32'(acc_log[$] - m_hs_cyc), 32'd1);
        wait_quiet();

        // Reset during EXEC discards the operation and restores the A-first tie-break.
        drive_a(3'd0, 4'h3, 4'h3);
        tick();
        drive_a(3'd5, 4'h7, 4'h1);
        drive_b(3'd1, 4'h2, 4'h8);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fire_log.delete();
        wait_fired();
        check("t5_a_wins_tie", 32'(fire_log.size() == 2 && fire_log[0] == 0), 32'd1);
        wait_quiet();

        // Back-to-back A operations with the consumer always ready.
        acc_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive_a(3'($urandom_range(0, 5)), N'($urandom), N'($urandom));
            wait_fired();
        end
        for (int i = 1; i < acc_log.size(); i++) begin
            check("t6_accept_period", 32'(acc_log[i] - acc_log[i-1]), 32'd3);
        end
        wait_quiet();

        // Random traffic including illegal opcodes and response back-pressure.
        repeat (400) begin
            if (!a_valid && $urandom_range(0, 2) == 0)
                drive_a(3'($urandom_range(0, 7)), N'($urandom), N'($urandom));
            if (!b_valid && $urandom_range(0, 2) == 0)
                drive_b(3'($urandom_range(0, 7)), N'($urandom), N'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        resp_ready = 1'b1;
        wait_quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Shares one N-bit ALU logic unit, including its 6-way result selector, between two requesters, A and B. Each requester submits an opcode and two operands over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand and select lines for one execute cycle, registers the result, and returns it with a requester tag over a second valid/ready handshake. It sits between the instruction front-ends and the ALU.

## Interface
Parameters:
- N, 4, operand/result width (≥1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A's operation accepted this cycle
- a_op  in  3  A opcode (0–5 legal)
- a_x, a_y  in  N  A operands
- b_valid, b_ready, b_op, b_x, b_y: same as A, for requester B
- alu_x, alu_y  out  N  operands to the ALU
- alu_sel  out  3  ALU result-select code
- alu_result  in  N  combinational ALU result for alu_x/alu_y/alu_sel
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  0 = A, 1 = B
- resp_data  out  N  result
- resp_err  out  1  opcode was illegal (6 or 7)

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- IDLE:
  - Grant one valid requester; its ready is 1 combinationally, the other's is 0.
  - With exactly one valid, grant that one.
  - With both valid, grant the one not granted last. `last_grant` resets to B, so A wins the first tie.
  - On grant: register op/x/y/id, update `last_grant`, go to EXEC. No valid requester: stay in IDLE.
- EXEC (exactly one cycle):
  - alu_x/alu_y driven from registered operands.
  - Legal op: alu_sel = op. Illegal op: alu_sel = 0, so the undriven mux default is never selected.
  - At the clock edge, capture alu_result into resp_data; resp_data = 0 if illegal. Set resp_err = illegal. Go to HOLD.
- HOLD:
  - resp_valid = 1. resp_id/data/err stable until the handshake completes.
  - resp_valid & resp_ready → IDLE. Otherwise stay in HOLD.
- a_ready and b_ready are 0 outside IDLE.
- Ready may depend on valid. Valid never depends on ready.
- Requests not granted are not dropped. The requester holds valid and payload until ready.

## Timing
- Reset values: a_ready = b_ready = 0, alu_x = alu_y = 0, alu_sel = 0, resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0, last_grant = B.
- Accept at edge T. EXEC during cycle T+1. resp_valid = 1 from T+2.
- Minimum 3 cycles per operation; the next accept is possible in the cycle after the response handshake.
- alu_x/alu_y/alu_sel hold their last EXEC values outside EXEC (no toggling).
- rst asserted in any state: immediate return to reset values. An in-flight transaction is discarded and no response is produced.
- resp_ready while resp_valid = 0: ignored.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` 3-bit opcode enum, values 0–5
  - `ALU_OP_COUNT = 6`
  - `sched_state_t` enum {IDLE, EXEC, HOLD}
  - `req_id_t`
- Sub-module `rr_arbiter2`: purely combinational grant logic from two valids plus `last_grant`. The `last_grant` register stays in the scheduler.
- The ALU itself sits outside this block and is connected at the parent level.

## Test plan
- N = 4, A: op = 2, x = 4'hA, y = 4'h3, B idle. Expect a_ready in cycle 0; alu_sel = 2 in cycle 1; resp_valid, resp_id = 0, resp_data = the ALU's result in cycle 2.
- A and B valid together after reset, twice in a row. Expect grant order A, B, A, B; each response tagged correctly.
- Illegal op 7 from B. Expect alu_sel = 0 during EXEC, resp_err = 1, resp_data = 0, resp_id = 1.
- resp_ready held 0 for 5 cycles in HOLD. Expect resp fields stable, both readies 0, no new accept; accept resumes in the cycle after the handshake.
- rst pulsed during EXEC. Expect all outputs at reset values immediately, no response afterward, and A winning the next tie.
- Back-to-back A ops with resp_ready tied 1. Expect one accept every 3 cycles exactly.
